gray_to_bin_tracker: RTL and testbench

//  Receive-side counterpart of the bintogray encoder. Samples an asynchronous

---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray_sync.sv | 34 +++
 rtl/gray_to_bin_tracker.sv | 120 ++++++++++++
 tb/tb_gray_to_bin_tracker.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code receive path: FSM state encodings
// and reference conversion functions at a fixed maximum width.
package gray_pkg;

  // Widest code the reference functions handle; narrower codes are
  // zero-extended, which leaves their low bits converting correctly.
  localparam int GRAY_MAX_W = 32;

  // Tracker FSM encodings
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } state_t;

  // Gray -> binary: b[i] is the XOR of g[MAX-1:i]
  function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int k = 1; k < GRAY_MAX_W; k++) begin
      b = b ^ (g >> k);
    end
    return b;
  endfunction

  // Binary -> Gray: each bit is the XOR of itself and its upper neighbour
  function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for an asynchronous WIDTH-bit Gray-coded bus.
// Because only one bit of a Gray code changes per step, a per-bit flop
// chain yields either the old or the new code, never a mixture.
module gray_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  // Shift the sampled code through the chain; synchronous reset clears every stage
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so each stage
    // captures its neighbour's value from before the edge.
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_to_bin_tracker.sv
// Receive-side Gray tracker: synchronises an asynchronous Gray code,
// decodes it to binary, classifies each change as +1 / -1 / illegal,
// and maintains direction pulses, a signed position and a sticky error.
module gray_to_bin_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int POS_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 en,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 err,
  output logic [POS_WIDTH-1:0] pos
);

  logic [WIDTH-1:0] w_gray_sync;
  logic [WIDTH-1:0] w_bin_new;
  logic             w_is_up;
  logic             w_is_dn;

  state_t                r_state;
  logic [WIDTH-1:0]      r_bin;
  logic                  r_valid;
  logic                  r_step_up;
  logic                  r_step_dn;
  logic                  r_err;
  logic [POS_WIDTH-1:0]  r_pos;

  gray_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (gray_in),
    .o_sync  (w_gray_sync)
  );

  // Decode the synchronised Gray code, MSB first
  always_comb begin
    // NOTE: the MSB is assigned before the loop so every bit of the local
    // result is written on every pass and no latch is inferred.
    logic [WIDTH-1:0] v_bin;
    v_bin[WIDTH-1] = w_gray_sync[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      v_bin[i] = v_bin[i+1] ^ w_gray_sync[i];
    end
    w_bin_new = v_bin;
  end

  // Adjacency relative to the last accepted code; WIDTH-bit sums wrap naturally
  assign w_is_up = (w_bin_new == r_bin + WIDTH'(1));
  assign w_is_dn = (w_bin_new == r_bin - WIDTH'(1));

  // Tracker FSM with registered outputs, position accumulator and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bin     <= '0;
      r_valid   <= 1'b0;
      r_step_up <= 1'b0;
      r_step_dn <= 1'b0;
      r_err     <= 1'b0;
      r_pos     <= '0;
    end else begin
      r_step_up <= 1'b0;
      r_step_dn <= 1'b0;
      // A fresh error later in this block overrides the clear
      if (clr_err) begin
        r_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          r_bin   <= w_bin_new;
          r_valid <= 1'b1;
          r_state <= en ? ST_TRACK : ST_IDLE;
        end
        ST_TRACK: begin
          if (!en) begin
            r_state <= ST_IDLE;
          end else if (w_is_up) begin
            r_bin     <= w_bin_new;
            r_step_up <= 1'b1;
            r_pos     <= r_pos + POS_WIDTH'(1);
          end else if (w_is_dn) begin
            r_bin     <= w_bin_new;
            r_step_dn <= 1'b1;
            r_pos     <= r_pos - POS_WIDTH'(1);
          end else if (w_bin_new != r_bin) begin
            // Non-adjacent jump: resynchronise to the new code and flag it
            r_bin <= w_bin_new;
            r_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bin_out   = r_bin;
  assign bin_valid = r_valid;
  assign step_up   = r_step_up;
  assign step_dn   = r_step_dn;
  assign err       = r_err;
  assign pos       = r_pos;

endmodule

// File: tb/tb_gray_to_bin_tracker.sv
// Directed bench for gray_to_bin_tracker (WIDTH=4, SYNC_STAGES=2, POS_WIDTH=16).
module tb_gray_to_bin_tracker;
  import gray_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  gray_in;
  logic        en;
  logic        clr_err;
  logic [3:0]  bin_out;
  logic        bin_valid;
  logic        step_up;
  logic        step_dn;
  logic        err;
  logic [15:0] pos;

  int n_cmp;
  int n_bad;

  logic [3:0] exp_bin;

  gray_to_bin_tracker #(
    .WIDTH       (4),
    .SYNC_STAGES (2),
    .POS_WIDTH   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .en        (en),
    .clr_err   (clr_err),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .err       (err),
    .pos       (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply a Gray code and check the full SYNC_STAGES+1 latency and pulse shape
  task automatic move(input string tag, input logic [3:0] g, input logic [3:0] nb,
                      input logic up, input logic dn);
    gray_in = g;
    tick(2);
    check({tag, "/hold"}, 32'(bin_out), 32'(exp_bin));
    check({tag, "/nopulse_early"}, 32'({step_up, step_dn}), 32'd0);
    tick(1);
    check({tag, "/bin"}, 32'(bin_out), 32'(nb));
    check({tag, "/up"}, 32'(step_up), 32'(up));
    check({tag, "/dn"}, 32'(step_dn), 32'(dn));
    exp_bin = nb;
    tick(1);
    check({tag, "/pulse_end"}, 32'({step_up, step_dn}), 32'd0);
  endtask

  initial begin
    logic [31:0] g_full;
    n_cmp   = 0;
    n_bad   = 0;
    exp_bin = 4'd0;
    rst     = 1'b1;
    en      = 1'b1;
    clr_err = 1'b0;
    gray_in = 4'b0000;

    // 1: reset state, then acquisition
    tick(1);
    check("rst/bin", 32'(bin_out), 32'd0);
    check("rst/valid", 32'(bin_valid), 32'd0);
    check("rst/pos", 32'(pos), 32'd0);
    check("rst/err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(1);
    check("acq/not_yet_valid", 32'(bin_valid), 32'd0);
    tick(2);
    check("acq/bin", 32'(bin_out), 32'd0);
    check("acq/valid", 32'(bin_valid), 32'd1);
    check("acq/pulses", 32'({step_up, step_dn}), 32'd0);

    // 2: walk up 0..3
    move("up1", 4'b0001, 4'd1, 1'b1, 1'b0);
    move("up2", 4'b0011, 4'd2, 1'b1, 1'b0);
    move("up3", 4'b0010, 4'd3, 1'b1, 1'b0);
    check("walk/pos", 32'(pos), 32'd3);
    check("walk/err", 32'(err), 32'd0);

    // 3: back down to 0, then wrap 0 -> 15 and 15 -> 0
    move("dn2", 4'b0011, 4'd2, 1'b0, 1'b1);
    move("dn1", 4'b0001, 4'd1, 1'b0, 1'b1);
    move("dn0", 4'b0000, 4'd0, 1'b0, 1'b1);
    check("back/pos", 32'(pos), 32'd0);
    move("wrap_dn", 4'b1000, 4'd15, 1'b0, 1'b1);
    check("wrap_dn/pos", 32'(pos), 32'h0000_FFFF);
    move("wrap_up", 4'b0000, 4'd0, 1'b1, 1'b0);
    check("wrap_up/pos", 32'(pos), 32'd0);
    check("wrap/err", 32'(err), 32'd0);

    // 4: single-bit Gray change that is not adjacent in binary (0 -> 7)
    move("jump7", 4'b0100, 4'd7, 1'b0, 1'b0);
    check("jump7/err", 32'(err), 32'd1);
    check("jump7/pos", 32'(pos), 32'd0);
    tick(2);
    check("jump7/sticky", 32'(err), 32'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr/err", 32'(err), 32'd0);

    // 5: disabled tracking holds outputs; re-enable re-acquires without a step
    en = 1'b0;
    tick(1);
    gray_in = 4'b0011;
    tick(4);
    check("idle/bin", 32'(bin_out), 32'd7);
    check("idle/valid", 32'(bin_valid), 32'd1);
    check("idle/pos", 32'(pos), 32'd0);
    check("idle/err", 32'(err), 32'd0);
    en = 1'b1;
    tick(2);
    check("reacq/bin", 32'(bin_out), 32'd2);
    check("reacq/pulses", 32'({step_up, step_dn}), 32'd0);
    check("reacq/pos", 32'(pos), 32'd0);
    tick(1);
    check("reacq/err", 32'(err), 32'd0);
    exp_bin = 4'd2;

    // New error in the same cycle as clr_err: error wins (2 -> 4)
    gray_in = 4'b0110;
    tick(2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_race/err", 32'(err), 32'd1);
    check("clr_race/bin", 32'(bin_out), 32'd4);
    exp_bin = 4'd4;

    // 6: walk up five steps (4 -> 9) then reset mid-operation
    for (int b = 5; b <= 9; b++) begin
      g_full = bin_to_gray(32'(b));
      move($sformatf("walk%0d", b), g_full[3:0], 4'(b), 1'b1, 1'b0);
    end
    check("pre_rst/pos", 32'(pos), 32'd5);
    check("pre_rst/err", 32'(err), 32'd1);
    rst = 1'b1;
    tick(1);
    check("midrst/bin", 32'(bin_out), 32'd0);
    check("midrst/valid", 32'(bin_valid), 32'd0);
    check("midrst/pulses", 32'({step_up, step_dn}), 32'd0);
    check("midrst/err", 32'(err), 32'd0);
    check("midrst/pos", 32'(pos), 32'd0);
    rst = 1'b0;
    // Synchroniser was cleared, so acquisition sees 0 before the live code 9 arrives
    tick(2);
    check("postrst/acq_bin", 32'(bin_out), 32'd0);
    check("postrst/valid", 32'(bin_valid), 32'd1);
    tick(1);
    check("postrst/bin", 32'(bin_out), 32'd9);
    check("postrst/err", 32'(err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
